i2s_mic_rx: RTL and testbench

- Upstream capture stage for the mic-select mux.
- Generates I2S bit clock (SCK) and word select (WS) for up to NUM_MICS I2S MEMS microphones on PMOD pins.
- Deserialises each mic's left-slot sample in parallel and presents all samples with a single-cycle valid strobe.
- The downstream mux picks one mic by switch setting and feeds the speaker path.

---
 rtl/i2s_pkg.sv | 8 +
 rtl/i2s_clk_gen.sv | 48 ++++
 rtl/i2s_mic_rx.sv | 93 +++++++++
 tb/tb_i2s_mic_rx.sv | 125 ++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// i2s_pkg: shared framing constants, sample type and SCK edge-event encoding for the I2S mic receiver.
package i2s_pkg;
  localparam int FRAME_BITS   = 64;
  localparam int SLOT_BITS    = 32;
  localparam int SAMPLE_W_DEF = 24;
  typedef logic signed [SAMPLE_W_DEF-1:0] sample_t;
  typedef enum logic [1:0] {EV_NONE, EV_RISE, EV_FALL} edge_ev_e;
endpackage

// File: rtl/i2s_clk_gen.sv
// i2s_clk_gen: divides clk_i into SCK, counts frame bits, drives WS and flags SCK edges.
module i2s_clk_gen
  import i2s_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  output logic                          sck_o,
  output logic                          ws_o,
  output logic [$clog2(FRAME_BITS)-1:0] bit_cnt_o,
  output edge_ev_e                      ev_o
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(FRAME_BITS);
  if (CLK_DIV < 4) begin : g_bad_div
    $error("CLK_DIV must be at least 4");
  end
  logic [DW-1:0] div_q, div_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          sck_q, ws_q, wrap;
  edge_ev_e      ev_q, ev_d;
  always_comb begin
    wrap  = div_q == DW'(CLK_DIV - 1);
    div_d = wrap ? '0 : div_q + 1'b1;
    ev_d  = !wrap ? EV_NONE : sck_q ? EV_FALL : EV_RISE;
    bit_d = (wrap && sck_q) ? bit_q + 1'b1 : bit_q;
  end
  // bit_q and ev_q move together, so an EV_FALL cycle already shows the new bit index
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      div_q <= '0;
      bit_q <= '0;
      sck_q <= 1'b0;
      ws_q  <= 1'b0;
      ev_q  <= EV_NONE;
    end else begin
      div_q <= div_d;
      bit_q <= bit_d;
      sck_q <= sck_q ^ wrap;
      ws_q  <= bit_d[BW-1];
      ev_q  <= ev_d;
    end
  assign sck_o     = sck_q;
  assign ws_o      = ws_q;
  assign bit_cnt_o = bit_q;
  assign ev_o      = ev_q;
endmodule

// File: rtl/i2s_mic_rx.sv
// i2s_mic_rx: clocks NUM_MICS I2S mics and captures each left-slot sample with one shared strobe.
// Define I2S_DC_BLOCK_EN to add a saturating first-order DC blocker (one extra cycle of latency).
module i2s_mic_rx
  import i2s_pkg::*;
#(
  parameter int CLK_DIV  = 16,
  parameter int NUM_MICS = 3,
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int DC_SHIFT = 10
) (
  input  logic                         clk_in,
  input  logic                         rst_n,
  input  logic [NUM_MICS-1:0]          mic_sd_in,
  output logic                         mic_sck_out,
  output logic                         mic_ws_out,
  output logic [NUM_MICS*SAMPLE_W-1:0] sample_out,
  output logic                         sample_valid_out
);
  if (SAMPLE_W >= SLOT_BITS || DC_SHIFT < 1 || DC_SHIFT >= SAMPLE_W) begin : g_bad_cfg
    $error("SAMPLE_W must fit in a slot and DC_SHIFT must lie in 1..SAMPLE_W-1");
  end
  logic [5:0]                          bit_cnt;
  edge_ev_e                            ev;
  logic [NUM_MICS-1:0]                 sync1_q, sync2_q;
  logic [NUM_MICS-1:0][SAMPLE_W-1:0]   sh_q, sh_d, raw_q;
  logic                                seen_q, cap_q, raw_vld_q, shift_en, last_bit;
  i2s_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk_i    (clk_in),
    .rst_ni   (rst_n),
    .sck_o    (mic_sck_out),
    .ws_o     (mic_ws_out),
    .bit_cnt_o(bit_cnt),
    .ev_o     (ev)
  );
  always_comb begin
    shift_en = ev == EV_RISE && bit_cnt != '0 && int'(bit_cnt) <= SAMPLE_W;
    last_bit = ev == EV_RISE && int'(bit_cnt) == SAMPLE_W;
  end
  for (genvar i = 0; i < NUM_MICS; i++) begin : g_mic
    assign sh_d[i] = shift_en ? {sh_q[i][SAMPLE_W-2:0], sync2_q[i]} : sh_q[i];
  end
  // the partial frame in flight at reset release is dropped until the first bit_cnt wrap
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      sh_q      <= '0;
      raw_q     <= '0;
      seen_q    <= 1'b0;
      cap_q     <= 1'b0;
      raw_vld_q <= 1'b0;
    end else begin
      sync1_q   <= mic_sd_in;
      sync2_q   <= sync1_q;
      sh_q      <= sh_d;
      seen_q    <= seen_q | (ev == EV_FALL && bit_cnt == '0);
      cap_q     <= last_bit && seen_q;
      raw_vld_q <= cap_q;
      if (cap_q) raw_q <= sh_q;
    end
`ifdef I2S_DC_BLOCK_EN
  localparam int EW = SAMPLE_W + 2;
  localparam logic signed [EW-1:0] Y_MAX = {3'b000, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [EW-1:0] Y_MIN = {3'b111, {(SAMPLE_W-1){1'b0}}};
  logic [NUM_MICS-1:0][SAMPLE_W-1:0] x_q, y_q, y_d;
  logic                              vld_q;
  for (genvar i = 0; i < NUM_MICS; i++) begin : g_dc
    logic signed [EW-1:0] x, xp, yp, acc;
    assign x       = EW'($signed(raw_q[i]));
    assign xp      = EW'($signed(x_q[i]));
    assign yp      = EW'($signed(y_q[i]));
    assign acc     = x - xp + yp - (yp >>> DC_SHIFT);
    assign y_d[i]  = acc > Y_MAX ? SAMPLE_W'(Y_MAX) : acc < Y_MIN ? SAMPLE_W'(Y_MIN) : acc[SAMPLE_W-1:0];
  end
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) begin
      x_q   <= '0;
      y_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= raw_vld_q;
      if (raw_vld_q) begin
        x_q <= raw_q;
        y_q <= y_d;
      end
    end
  assign sample_out       = y_q;
  assign sample_valid_out = vld_q;
`else
  assign sample_out       = raw_q;
  assign sample_valid_out = raw_vld_q;
`endif
endmodule

// File: tb/tb_i2s_mic_rx.sv
// tb_i2s_mic_rx: random I2S mic traffic against a frame-level timing/value model of the receiver.
`timescale 1ns/1ps
module tb_i2s_mic_rx;
  localparam int CD = 16;
  localparam int N  = 3;
  localparam int W  = 24;
  localparam int FR = 128 * CD;
  logic             clk_in = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     mic_sd_in = '0;
  logic             mic_sck_out, mic_ws_out, sample_valid_out;
  logic [N*W-1:0]   sample_out;
  int               total = 0;
  int               bad = 0;
  int               cyc = 0;
  int               n_st = 0;
  logic [N*W-1:0]   last_exp = '0;
  logic [W-1:0]     vals [16][N];
  int               fill [16];
  always #5 clk_in = ~clk_in;
  i2s_mic_rx dut (
    .clk_in          (clk_in),
    .rst_n           (rst_n),
    .mic_sd_in       (mic_sd_in),
    .mic_sck_out     (mic_sck_out),
    .mic_ws_out      (mic_ws_out),
    .sample_out      (sample_out),
    .sample_valid_out(sample_valid_out)
  );
  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at cyc=%0d", tag, got, exp, cyc);
    end
  endtask
  task automatic init_vals();
    for (int f = 0; f < 16; f++) begin
      for (int i = 0; i < N; i++) vals[f][i] = W'($urandom);
      fill[f] = 0;
    end
    vals[1][0] = 24'h800001; vals[1][1] = 24'h7FFFFF; vals[1][2] = 24'h000000;
    for (int i = 0; i < N; i++) begin
      vals[2][i] = 24'h123456;
      vals[3][i] = 24'hFFFFFF;
      vals[4][i] = 24'h000000;
    end
    fill[2] = 1; fill[3] = 1; fill[4] = 2;
  endtask
  // mic line level after the m-th SCK fall since reset release
  function automatic logic bit_for(input int m, input int i);
    int b = m % 64;
    int f = (m / 64 > 15) ? 15 : m / 64;
    if (b >= 1 && b <= W) return vals[f][i][W-b];
    if (fill[f] == 1) return 1'b1;
    if (fill[f] == 2) return 1'b0;
    return 1'($urandom);
  endfunction
  function automatic logic [N*W-1:0] exp_word(input int f);
    return {vals[f][2], vals[f][1], vals[f][0]};
  endfunction
  // n-th strobe belongs to frame n+1 and lands two clocks after that frame's bit-24 SCK rise
  function automatic int strobe_at(input int n);
    return (2 * (64 * (n + 1) + W) + 1) * CD + 2;
  endfunction
  always @(posedge clk_in or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  always @(negedge clk_in)
    if (!rst_n) begin
      n_st     <= 0;
      last_exp <= '0;
    end else if (cyc > 0) begin
      if (sample_valid_out || cyc == strobe_at(n_st)) begin
        check_eq("strobe_cycle", 72'(cyc), 72'(strobe_at(n_st)));
        check_eq("strobe_flag", 72'(sample_valid_out), 72'(1));
        check_eq("sample", 72'(sample_out), 72'(exp_word(n_st + 1)));
        last_exp <= exp_word(n_st + 1);
        n_st     <= n_st + 1;
      end else if (cyc % 8 == 3) begin
        check_eq("sck", 72'(mic_sck_out), 72'((cyc / CD) % 2));
        check_eq("ws", 72'(mic_ws_out), 72'((cyc / (64 * CD)) % 2));
        check_eq("hold", 72'(sample_out), 72'(last_exp));
      end
    end
  initial begin
    int m;
    forever begin
      @(negedge clk_in);
      if (rst_n && cyc > 0 && cyc % (2 * CD) == 0) begin
        m = cyc / (2 * CD);
        #($urandom_range(1, 60));
        for (int i = 0; i < N; i++) mic_sd_in[i] = bit_for(m, i);
      end
    end
  end
  task automatic check_reset(input string tag);
    check_eq({tag, "_sck"}, 72'(mic_sck_out), 72'(0));
    check_eq({tag, "_ws"}, 72'(mic_ws_out), 72'(0));
    check_eq({tag, "_sample"}, 72'(sample_out), 72'(0));
    check_eq({tag, "_valid"}, 72'(sample_valid_out), 72'(0));
  endtask
  initial begin
    init_vals();
    repeat (3) @(negedge clk_in);
    check_reset("rst");
    rst_n = 1'b1;
    repeat (12 * FR + 50) @(negedge clk_in);
    rst_n = 1'b0;
    init_vals();
    repeat (3) @(negedge clk_in);
    rst_n = 1'b1;
    repeat ((64 * 2 + 12) * 2 * CD + 7) @(negedge clk_in);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    repeat (4) @(negedge clk_in);
    init_vals();
    rst_n = 1'b1;
    repeat (5 * FR + 50) @(negedge clk_in);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
